// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, owner ids, default timeout.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Saturating wait counter for one memory transaction; expired flags the cycle that
// would make the wait reach TIMEOUT cycles (never asserts when TIMEOUT is 0).
module mem_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (inc && cnt != {CW{1'b1}}) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt counts completed waiting cycles, so the abort lands on the TIMEOUT-th one
  assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between fetch and load/store,
// with one-cycle done pulses, held read data and a timeout abort that flags err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  state_t state_q, state_d;
  owner_t last_owner;
  logic   grant_i, grant_d, finish, abort;
  logic   expired, waiting;

  assign waiting = (state_q != IDLE) && !mem_ready;

  mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_i || grant_d),
    .inc     (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        // on a tie the requester that did not own the previous grant wins
        if (i_req && (!d_req || last_owner == OWN_D)) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWN_I;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      if (grant_i) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_be     <= 4'hF;
        mem_addr   <= i_addr;
        last_owner <= OWN_I;
      end
      if (grant_d) begin
        mem_req    <= 1'b1;
        mem_we     <= d_we;
        mem_be     <= d_be;
        mem_addr   <= d_addr;
        mem_wdata  <= d_wdata;
        last_owner <= OWN_D;
      end
      if (finish || abort) begin
        mem_req <= 1'b0;
        err     <= abort;
        if (state_q == BUSY_I) begin
          i_done  <= 1'b1;
          i_rdata <= finish ? mem_rdata : '0;
        end else begin
          d_done  <= 1'b1;
          d_rdata <= finish ? mem_rdata : '0;
        end
      end
    end
  end

endmodule
